// File: rtl/fast_control_pkg.sv
// Shared definitions for the fast-control receive path: command bit map, codeword layout, lock FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fast_control_pkg;

    // Command bit positions within the decoded 8-bit fast-control word
    localparam int FC_BCR          = 0;
    localparam int FC_L1A          = 1;
    localparam int FC_LINK_RESET   = 2;
    localparam int FC_BUFFER_CLEAR = 3;
    localparam int FC_CALIB        = 5;

    // Hamming(8,4) codeword bit positions, identical to hamming84_enc
    localparam int HAM_P1  = 0;
    localparam int HAM_P2  = 1;
    localparam int HAM_D0  = 2;
    localparam int HAM_P3  = 3;
    localparam int HAM_D1  = 4;
    localparam int HAM_D2  = 5;
    localparam int HAM_D3  = 6;
    localparam int HAM_PAR = 7;

    // Width of bunch-crossing numbers (orbit length, bx_id, l1a_bx)
    localparam int BX_W = 12;

    typedef enum logic [1:0] {
        LOCK_UNLOCKED = 2'd0,
        LOCK_ALIGNING = 2'd1,
        LOCK_LOCKED   = 2'd2
    } lock_state_t;

    // Decoded command pulses carried down the pipeline
    typedef struct packed {
        logic calib_pulse;
        logic buffer_clear;
        logic link_reset;
        logic l1a;
        logic bcr;
    } fc_cmd_t;

endpackage

// File: rtl/fast_control_rx_if.sv
// Bundle of the fast-control word input, orbit configuration and decoded/status outputs.
// Latency: n/a (wiring only).
// Backpressure: none; the stream delivers one word per bunch crossing.
interface fast_control_rx_if
    import fast_control_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic [15:0]      fc_stream_enc;
    logic [BX_W-1:0]  orb_length;
    logic             counters_clear;

    logic             bcr;
    logic             l1a;
    logic             link_reset;
    logic             buffer_clear;
    logic             calib_pulse;
    logic [BX_W-1:0]  bx_id;
    logic [BX_W-1:0]  l1a_bx;
    logic             locked;
    logic [31:0]      l1a_count;
    logic [CNT_W-1:0] sec_count;
    logic [CNT_W-1:0] ded_count;
    logic [CNT_W-1:0] misalign_count;

    // Link side / slow-control side that drives words and reads status
    modport master (
        output fc_stream_enc, orb_length, counters_clear,
        input  bcr, l1a, link_reset, buffer_clear, calib_pulse,
        input  bx_id, l1a_bx, locked, l1a_count, sec_count, ded_count, misalign_count
    );

    // The receiver
    modport slave (
        input  fc_stream_enc, orb_length, counters_clear,
        output bcr, l1a, link_reset, buffer_clear, calib_pulse,
        output bx_id, l1a_bx, locked, l1a_count, sec_count, ded_count, misalign_count
    );

endinterface

// File: rtl/hamming84_dec.sv
// Hamming(8,4) SEC-DED nibble decoder: corrects one flipped bit, flags two flipped bits.
// Latency: combinational.
// Backpressure: none.
module hamming84_dec
    import fast_control_pkg::*;
(
    input  logic [7:0] enc_in,
    output logic [3:0] data_out,
    output logic       single_err,
    output logic       double_err
);

    logic [2:0] syn;
    logic       par_err;
    logic [3:0] raw_data;
    logic [3:0] fix_mask;

    // Syndrome/parity check and correction of the data bits only; parity-bit hits need no data fix
    always_comb begin
        syn[0]   = enc_in[HAM_P1] ^ enc_in[HAM_D0] ^ enc_in[HAM_D1] ^ enc_in[HAM_D3];
        syn[1]   = enc_in[HAM_P2] ^ enc_in[HAM_D0] ^ enc_in[HAM_D2] ^ enc_in[HAM_D3];
        syn[2]   = enc_in[HAM_P3] ^ enc_in[HAM_D1] ^ enc_in[HAM_D2] ^ enc_in[HAM_D3];
        par_err  = ^enc_in;
        raw_data = {enc_in[HAM_D3], enc_in[HAM_D2], enc_in[HAM_D1], enc_in[HAM_D0]};

        // Syndrome value s names codeword bit s-1: 3->d0, 5->d1, 6->d2, 7->d3
        fix_mask = {syn == 3'd7, syn == 3'd6, syn == 3'd5, syn == 3'd3};

        single_err = par_err;
        double_err = !par_err && (syn != 3'd0);

        if (double_err) begin
            data_out = 4'b0000;
        end else if (single_err) begin
            data_out = raw_data ^ fix_mask;
        end else begin
            data_out = raw_data;
        end
    end

endmodule

// File: rtl/fast_control_rx.sv
// Fast-control receiver: SEC-DED decode of the per-BX word, command pulses, BCR-locked bx_id, error counters.
// Latency: 3 clk_bx from word to pulses/bx_id/locked; sec/ded/misalign counters one cycle later.
// Backpressure: none; one word consumed every clk_bx, nothing ever stalls.
module fast_control_rx
    import fast_control_pkg::*;
#(
    parameter int LOCK_BCRS = 4,
    parameter int LOSE_BCRS = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk_bx,
    input  logic             reset,
    fast_control_rx_if.slave fc
);

    localparam int GOOD_W = $clog2(LOCK_BCRS + 1);
    localparam int BAD_W  = $clog2(LOSE_BCRS + 1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_BCRS);
    localparam logic [BAD_W-1:0]  BAD_LOSE  = BAD_W'(LOSE_BCRS);

    // Stage 1: raw word
    logic [15:0]       enc_s1;

    // Decoder outputs (combinational on stage 1)
    logic [3:0]        nib_lo;
    logic [3:0]        nib_hi;
    logic              lo_sec;
    logic              lo_ded;
    logic              hi_sec;
    logic              hi_ded;
    logic              unused_rsvd;

    // Stage 2: decoded command and per-BX error counts (0..2 each)
    fc_cmd_t           cmd_s2;
    logic [1:0]        sec_s2;
    logic [1:0]        ded_s2;

    // Stage 3: outputs, lock FSM, bx counter
    fc_cmd_t           cmd_s3;
    logic [1:0]        sec_s3;
    logic [1:0]        ded_s3;
    logic              fault_s3;
    lock_state_t       state_q;
    logic              locked_q;
    logic [GOOD_W-1:0] good_q;
    logic [GOOD_W-1:0] good_inc;
    logic [BAD_W-1:0]  bad_q;
    logic [BAD_W-1:0]  bad_inc;
    logic [BX_W-1:0]   bx_id_q;
    logic [BX_W-1:0]   bx_last;
    logic [BX_W-1:0]   bx_wrap;
    logic [BX_W-1:0]   bx_nxt;
    logic              bx_expected;
    logic [BX_W-1:0]   l1a_bx_q;
    logic [31:0]       l1a_count_q;

    // Stage 4: saturating counters
    logic [CNT_W-1:0]  sec_cnt_q;
    logic [CNT_W-1:0]  ded_cnt_q;
    logic [CNT_W-1:0]  mis_cnt_q;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W + 1)'(inc);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    hamming84_dec u_dec_lo (
        .enc_in     (enc_s1[7:0]),
        .data_out   (nib_lo),
        .single_err (lo_sec),
        .double_err (lo_ded)
    );

    hamming84_dec u_dec_hi (
        .enc_in     (enc_s1[15:8]),
        .data_out   (nib_hi),
        .single_err (hi_sec),
        .double_err (hi_ded)
    );

    // Command bits 4, 6 and 7 are reserved and deliberately dropped
    assign unused_rsvd = ^{nib_hi[3:2], nib_hi[0]};

    // Stage 1: capture the incoming word
    always_ff @(posedge clk_bx) begin
        if (reset) begin
            enc_s1 <= '0;
        end else begin
            enc_s1 <= fc.fc_stream_enc;
        end
    end

    // Stage 2: register corrected command bits and how many nibbles needed SEC / hit DED
    always_ff @(posedge clk_bx) begin
        if (reset) begin
            cmd_s2 <= '0;
            sec_s2 <= '0;
            ded_s2 <= '0;
        end else begin
            cmd_s2.bcr          <= nib_lo[FC_BCR];
            cmd_s2.l1a          <= nib_lo[FC_L1A];
            cmd_s2.link_reset   <= nib_lo[FC_LINK_RESET];
            cmd_s2.buffer_clear <= nib_lo[FC_BUFFER_CLEAR];
            cmd_s2.calib_pulse  <= nib_hi[FC_CALIB - 4];
            sec_s2              <= {1'b0, lo_sec} + {1'b0, hi_sec};
            ded_s2              <= {1'b0, lo_ded} + {1'b0, hi_ded};
        end
    end

    // Next bx_id: free-running wrap, realigned to 0 by a bcr only while not yet locked
    always_comb begin
        bx_last     = fc.orb_length - BX_W'(1);
        bx_expected = (bx_id_q == bx_last);
        bx_wrap     = (bx_id_q >= bx_last) ? '0 : bx_id_q + BX_W'(1);
        bx_nxt      = bx_wrap;
        good_inc    = good_q + GOOD_W'(1);
        bad_inc     = bad_q + BAD_W'(1);
        if (cmd_s2.bcr && ((state_q == LOCK_UNLOCKED) ||
                           ((state_q == LOCK_ALIGNING) && !bx_expected))) begin
            bx_nxt = '0;
        end
    end

    // Stage 3: command pulses, bx_id, L1A capture and the BCR lock state machine
    always_ff @(posedge clk_bx) begin
        if (reset) begin
            cmd_s3      <= '0;
            sec_s3      <= '0;
            ded_s3      <= '0;
            fault_s3    <= 1'b0;
            state_q     <= LOCK_UNLOCKED;
            locked_q    <= 1'b0;
            good_q      <= '0;
            bad_q       <= '0;
            bx_id_q     <= '0;
            l1a_bx_q    <= '0;
            l1a_count_q <= '0;
        end else begin
            cmd_s3   <= cmd_s2;
            sec_s3   <= sec_s2;
            ded_s3   <= ded_s2;
            fault_s3 <= 1'b0;
            bx_id_q  <= bx_nxt;

            if (cmd_s2.l1a) begin
                l1a_bx_q <= bx_nxt;
            end
            if (fc.counters_clear) begin
                l1a_count_q <= '0;
            end else if (cmd_s2.l1a) begin
                l1a_count_q <= l1a_count_q + 32'd1;
            end

            case (state_q)
                LOCK_UNLOCKED: begin
                    if (cmd_s2.bcr) begin
                        good_q  <= GOOD_W'(1);
                        state_q <= LOCK_ALIGNING;
                    end
                end
                LOCK_ALIGNING: begin
                    if (cmd_s2.bcr && bx_expected) begin
                        good_q <= good_inc;
                        if (good_inc == GOOD_LOCK) begin
                            state_q  <= LOCK_LOCKED;
                            locked_q <= 1'b1;
                            bad_q    <= '0;
                        end
                    end else if (cmd_s2.bcr) begin
                        good_q <= GOOD_W'(1);
                    end else if (bx_expected) begin
                        state_q <= LOCK_UNLOCKED;
                    end
                end
                LOCK_LOCKED: begin
                    if (cmd_s2.bcr && bx_expected) begin
                        bad_q <= '0;
                    end else if (cmd_s2.bcr || bx_expected) begin
                        // Stray or missing BCR: count it but keep the established alignment
                        fault_s3 <= 1'b1;
                        bad_q    <= bad_inc;
                        if (bad_inc == BAD_LOSE) begin
                            state_q  <= LOCK_UNLOCKED;
                            locked_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= LOCK_UNLOCKED;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    // Stage 4: saturating error/alignment counters; clear wins over any increment
    always_ff @(posedge clk_bx) begin
        if (reset || fc.counters_clear) begin
            sec_cnt_q <= '0;
            ded_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else begin
            sec_cnt_q <= sat_add(sec_cnt_q, sec_s3);
            ded_cnt_q <= sat_add(ded_cnt_q, ded_s3);
            mis_cnt_q <= sat_add(mis_cnt_q, {1'b0, fault_s3});
        end
    end

    assign fc.bcr            = cmd_s3.bcr;
    assign fc.l1a            = cmd_s3.l1a;
    assign fc.link_reset     = cmd_s3.link_reset;
    assign fc.buffer_clear   = cmd_s3.buffer_clear;
    assign fc.calib_pulse    = cmd_s3.calib_pulse;
    assign fc.bx_id          = bx_id_q;
    assign fc.l1a_bx         = l1a_bx_q;
    assign fc.locked         = locked_q;
    assign fc.l1a_count      = l1a_count_q;
    assign fc.sec_count      = sec_cnt_q;
    assign fc.ded_count      = ded_cnt_q;
    assign fc.misalign_count = mis_cnt_q;

endmodule

// File: tb/tb_fast_control_rx.sv
// Scoreboard bench for fast_control_rx: lock/unlock, SEC/DED, L1A capture, counter clear, reset flush.
// Latency: expected entries retire three words after they are driven.
// Backpressure: none.
module tb_fast_control_rx;
    import fast_control_pkg::*;

    localparam int ORB = 45;

    logic clk_bx = 1'b0;
    logic reset  = 1'b1;

    always #5 clk_bx = ~clk_bx;

    fast_control_rx_if #(.CNT_W(16)) fc_bus ();

    fast_control_rx #(
        .LOCK_BCRS (4),
        .LOSE_BCRS (3),
        .CNT_W     (16)
    ) dut (
        .clk_bx (clk_bx),
        .reset  (reset),
        .fc     (fc_bus)
    );

    typedef struct {
        logic bcr;
        logic l1a;
        logic lr;
        logic bc;
        logic calib;
        int   bx;
        logic locked;
        int   l1a_bx;
        int   l1a_cnt;
        int   sec;
        int   ded;
        int   mis;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state (0 unlocked, 1 aligning, 2 locked)
    int m_state, m_bx, m_good, m_bad, m_l1a_bx, m_l1a_cnt, m_sec, m_ded, m_mis;
    bit c1, c2;
    int tx_ph = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [7:0] enc_nib(input logic [3:0] d);
        logic [7:0] w;
        w[0] = d[0] ^ d[1] ^ d[3];
        w[1] = d[0] ^ d[2] ^ d[3];
        w[2] = d[0];
        w[3] = d[1] ^ d[2] ^ d[3];
        w[4] = d[1];
        w[5] = d[2];
        w[6] = d[3];
        w[7] = ^w[6:0];
        return w;
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.bcr = 0; e.l1a = 0; e.lr = 0; e.bc = 0; e.calib = 0;
        e.bx = 0; e.locked = 0; e.l1a_bx = 0; e.l1a_cnt = 0;
        e.sec = 0; e.ded = 0; e.mis = 0;
        return e;
    endfunction

    task automatic model_push(input logic [7:0] d, input int nsec, input int nded, input bit clr);
        exp_t e;
        bit   bcr   = d[0];
        bit   expd  = (m_bx == ORB - 1);
        int   nx    = expd ? 0 : m_bx + 1;
        bit   fault = 0;
        case (m_state)
            0: if (bcr) begin nx = 0; m_good = 1; m_state = 1; end
            1: begin
                if (bcr && expd) begin
                    m_good++;
                    if (m_good == 4) begin m_state = 2; m_bad = 0; end
                end else if (bcr) begin
                    nx = 0; m_good = 1;
                end else if (expd) begin
                    m_state = 0;
                end
            end
            default: begin
                if (bcr && expd) m_bad = 0;
                else if (bcr || expd) begin
                    fault = 1; m_bad++;
                    if (m_bad == 3) m_state = 0;
                end
            end
        endcase
        m_bx = nx;
        e = zero_exp();
        e.bcr = d[0]; e.l1a = d[1]; e.lr = d[2]; e.bc = d[3]; e.calib = d[5];
        e.bx = nx;
        e.locked = (m_state == 2);
        if (d[1]) m_l1a_bx = nx;
        e.l1a_bx = m_l1a_bx;
        if (clr) m_l1a_cnt = 0;
        else if (d[1]) m_l1a_cnt++;
        e.l1a_cnt = m_l1a_cnt;
        // Error counters lag one cycle: this entry shows totals of earlier words
        if (clr) begin m_sec = 0; m_ded = 0; m_mis = 0; end
        e.sec = m_sec; e.ded = m_ded; e.mis = m_mis;
        m_sec += nsec; m_ded += nded; m_mis += int'(fault);
        sb.push_back(e);
    endtask

    task automatic compare(input exp_t e);
        chk("bcr",          fc_bus.bcr,            e.bcr);
        chk("l1a",          fc_bus.l1a,            e.l1a);
        chk("link_reset",   fc_bus.link_reset,     e.lr);
        chk("buffer_clear", fc_bus.buffer_clear,   e.bc);
        chk("calib_pulse",  fc_bus.calib_pulse,    e.calib);
        chk("bx_id",        fc_bus.bx_id,          e.bx);
        chk("locked",       fc_bus.locked,         e.locked);
        chk("l1a_bx",       fc_bus.l1a_bx,         e.l1a_bx);
        chk("l1a_count",    fc_bus.l1a_count,      e.l1a_cnt);
        chk("sec_count",    fc_bus.sec_count,      e.sec);
        chk("ded_count",    fc_bus.ded_count,      e.ded);
        chk("misalign",     fc_bus.misalign_count, e.mis);
    endtask

    // One BX: retire the oldest expectation, drive a word, predict its outcome
    task automatic step(input logic [7:0] cmd, input logic [15:0] flip, input bit clr, input bit rst);
        int nlo, nhi;
        logic [7:0] d;
        @(posedge clk_bx);
        #1;
        if (sb.size() == 3) compare(sb.pop_front());
        reset = rst;
        fc_bus.fc_stream_enc = {enc_nib(cmd[7:4]), enc_nib(cmd[3:0])} ^ flip;
        if (rst) begin
            fc_bus.counters_clear = 1'b0;
            c1 = 0; c2 = 0;
            m_state = 0; m_bx = 0; m_good = 0; m_bad = 0;
            m_l1a_bx = 0; m_l1a_cnt = 0; m_sec = 0; m_ded = 0; m_mis = 0;
            sb.delete();
            sb.push_back(zero_exp());
            model_push(8'h00, 0, 0, 1'b0);
            model_push(8'h00, 0, 0, 1'b0);
        end else begin
            fc_bus.counters_clear = c2;
            c2 = c1;
            c1 = clr;
            nlo = $countones(flip[7:0]);
            nhi = $countones(flip[15:8]);
            d = cmd;
            if (nlo == 2) d[3:0] = 4'h0;
            if (nhi == 2) d[7:4] = 4'h0;
            model_push(d, int'(nlo == 1) + int'(nhi == 1), int'(nlo == 2) + int'(nhi == 2), clr);
        end
    endtask

    task automatic send(input logic [7:0] extra, input logic [15:0] flip, input bit clr, input bit nobcr);
        logic [7:0] c;
        c = extra;
        if (tx_ph == 0 && !nobcr) c[0] = 1'b1;
        step(c, flip, clr, 1'b0);
        tx_ph = (tx_ph + 1) % ORB;
    endtask

    task automatic idle_to(input int ph);
        while (tx_ph != ph) send(8'h00, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic run_orbit(input bit nobcr);
        for (int i = 0; i < ORB; i++) send(8'h00, 16'h0000, 1'b0, nobcr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of run, want finish before 1 ms");
        $fatal(1);
    end

    initial begin
        fc_bus.fc_stream_enc  = 16'h0000;
        fc_bus.orb_length     = 12'(ORB);
        fc_bus.counters_clear = 1'b0;
        repeat (2) @(posedge clk_bx);
        step(8'h00, 16'h0000, 1'b0, 1'b1);
        tx_ph = 0;

        // Acquire lock on a clean BCR train
        repeat (5) run_orbit(1'b0);

        // Every single-bit flip on an L1A word is corrected
        idle_to(5);
        for (int b = 0; b < 16; b++) send(8'h02, 16'h0001 << b, 1'b0, 1'b0);
        idle_to(0);
        run_orbit(1'b0);

        // Double error in the low nibble kills l1a, high nibble still gives calib
        idle_to(10);
        send(8'h22, 16'h0003, 1'b0, 1'b0);
        idle_to(0);

        // L1A capture, clear before it, clear coinciding with a second one
        idle_to(10);
        send(8'h00, 16'h0000, 1'b1, 1'b0);
        idle_to(20);
        send(8'h02, 16'h0000, 1'b0, 1'b0);
        idle_to(30);
        send(8'h02, 16'h0000, 1'b1, 1'b0);
        idle_to(0);

        // Remaining command bits, alone and combined with reserved bits set
        idle_to(12);
        send(8'h04, 16'h0000, 1'b0, 1'b0);
        send(8'h08, 16'h0000, 1'b0, 1'b0);
        send(8'h20, 16'h0000, 1'b0, 1'b0);
        send(8'hDE, 16'h0000, 1'b0, 1'b0);
        idle_to(0);

        // Stray BCR while locked: one fault, alignment kept
        idle_to(15);
        send(8'h01, 16'h0000, 1'b0, 1'b0);
        idle_to(10);
        send(8'h00, 16'h0000, 1'b1, 1'b0);
        idle_to(0);

        // Three missing BCRs drop lock
        repeat (3) run_orbit(1'b1);

        // Re-align, restart on an early BCR, then lock again
        repeat (2) run_orbit(1'b0);
        idle_to(30);
        step(8'h01, 16'h0000, 1'b0, 1'b0);
        tx_ph = 1;
        idle_to(0);
        repeat (5) run_orbit(1'b0);

        // Reset while locked
        idle_to(7);
        step(8'h00, 16'h0000, 1'b0, 1'b1);
        tx_ph = 8;
        idle_to(0);
        repeat (5) run_orbit(1'b0);

        // Reset with L1A words in flight
        idle_to(20);
        send(8'h02, 16'h0000, 1'b0, 1'b0);
        step(8'h02, 16'h0000, 1'b0, 1'b1);
        repeat (6) step(8'h00, 16'h0000, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
